sccb_target: RTL and testbench

SCCB_TARGET -- requirements
Module: sccb_target

---
 rtl/sccb_target.sv | 206 ++++++++++++++++++++
 tb/tb_sccb_target.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_target.sv
// SCCB/I2C-style register-access target with write strobes and read-back.
// Oversamples scl/sda on clk; drives sda open-drain (0 or z) only.
module sccb_target #(
    parameter logic [6:0] DEVICE_ID = 7'h21
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    output logic       wr_strobe,
    output logic [7:0] wr_reg,
    output logic [7:0] wr_data,
    output logic [7:0] rd_reg,
    input  logic [7:0] rd_data,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK,
        WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    state_t      state_q, state_d;
    logic        scl_s1_q, scl_s2_q, scl_p_q;
    logic        sda_s1_q, sda_s2_q, sda_p_q;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  sh_q, sh_d;
    logic        oe_q, oe_d;
    logic        ph_q, ph_d;
    logic        rw_q, rw_d;
    logic        busy_q, busy_d;
    logic        stb_q, stb_d;
    logic [7:0]  wr_reg_q, wr_reg_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [7:0]  rd_reg_q, rd_reg_d;

    logic        scl_rise, scl_fall, start, stop;
    logic [7:0]  byte_in;

    assign scl_rise = scl_s2_q & ~scl_p_q;
    assign scl_fall = ~scl_s2_q & scl_p_q;
    assign start    = scl_s2_q & scl_p_q & sda_p_q & ~sda_s2_q;
    assign stop     = scl_s2_q & scl_p_q & ~sda_p_q & sda_s2_q;
    assign byte_in  = {sh_q[6:0], sda_s2_q};

    assign sda       = oe_q ? 1'b0 : 1'bz;
    assign wr_strobe = stb_q;
    assign wr_reg    = wr_reg_q;
    assign wr_data   = wr_data_q;
    assign rd_reg    = rd_reg_q;
    assign busy      = busy_q;

    // Synchronisers (idle bus = 1) and all protocol state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_s1_q  <= 1'b1;
            scl_s2_q  <= 1'b1;
            scl_p_q   <= 1'b1;
            sda_s1_q  <= 1'b1;
            sda_s2_q  <= 1'b1;
            sda_p_q   <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= 3'd0;
            sh_q      <= 8'h00;
            oe_q      <= 1'b0;
            ph_q      <= 1'b0;
            rw_q      <= 1'b0;
            busy_q    <= 1'b0;
            stb_q     <= 1'b0;
            wr_reg_q  <= 8'h00;
            wr_data_q <= 8'h00;
            rd_reg_q  <= 8'h00;
        end else begin
            scl_s1_q  <= scl;
            scl_s2_q  <= scl_s1_q;
            scl_p_q   <= scl_s2_q;
            sda_s1_q  <= sda;
            sda_s2_q  <= sda_s1_q;
            sda_p_q   <= sda_s2_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            oe_q      <= oe_d;
            ph_q      <= ph_d;
            rw_q      <= rw_d;
            busy_q    <= busy_d;
            stb_q     <= stb_d;
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
            rd_reg_q  <= rd_reg_d;
        end
    end

    // Next-state: START/STOP win over bit handling; ph_q splits each ACK
    // slot into its "drive" and "release" falling edges.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        oe_d      = oe_q;
        ph_d      = ph_q;
        rw_d      = rw_q;
        busy_d    = busy_q;
        stb_d     = 1'b0;
        wr_reg_d  = stb_q ? wr_reg_q + 8'd1 : wr_reg_q;
        wr_data_d = wr_data_q;
        rd_reg_d  = rd_reg_q;
        if (start) begin
            state_d = DEV_ADDR;
            cnt_d   = 3'd0;
            oe_d    = 1'b0;
            ph_d    = 1'b0;
            busy_d  = 1'b1;
        end else if (stop) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
            oe_d    = 1'b0;
            ph_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                DEV_ADDR: if (scl_rise) begin
                    sh_d  = byte_in;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        if (byte_in[7:1] == DEVICE_ID) begin
                            rw_d    = byte_in[0];
                            state_d = DEV_ACK;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = IGNORE;
                        end
                    end
                end
                REG_ADDR: if (scl_rise) begin
                    sh_d  = byte_in;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        wr_reg_d = byte_in;
                        rd_reg_d = byte_in;
                        state_d  = REG_ACK;
                    end
                end
                WDATA: if (scl_rise) begin
                    sh_d  = byte_in;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        wr_data_d = byte_in;
                        stb_d     = 1'b1;
                        state_d   = WDATA_ACK;
                    end
                end
                DEV_ACK, REG_ACK, WDATA_ACK: if (scl_fall) begin
                    if (!ph_q) begin
                        oe_d = 1'b1;
                        ph_d = 1'b1;
                    end else begin
                        oe_d  = 1'b0;
                        ph_d  = 1'b0;
                        cnt_d = 3'd0;
                        if (state_q == DEV_ACK && rw_q) begin
                            sh_d    = rd_data;
                            oe_d    = ~rd_data[7];
                            state_d = RDATA;
                        end else if (state_q == DEV_ACK) begin
                            state_d = REG_ADDR;
                        end else begin
                            state_d = WDATA;
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            ph_d    = 1'b0;
                            state_d = RDATA_ACK;
                        end
                    end else if (scl_fall) begin
                        sh_d = {sh_q[6:0], 1'b0};
                        oe_d = ~sh_q[6];
                    end
                end
                RDATA_ACK: begin
                    if (scl_fall && !ph_q) begin
                        oe_d = 1'b0;
                        ph_d = 1'b1;
                    end else if (scl_fall) begin
                        sh_d    = rd_data;
                        oe_d    = ~rd_data[7];
                        ph_d    = 1'b0;
                        cnt_d   = 3'd0;
                        state_d = RDATA;
                    end else if (scl_rise && ph_q) begin
                        if (sda_s2_q) state_d = IGNORE;
                        else rd_reg_d = rd_reg_q + 8'd1;
                    end
                end
                IDLE, IGNORE: begin
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sccb_target.sv
// Self-checking bench for sccb_target acting as bus initiator.
// Expected write strobes go through a queue checked by a monitor.
module tb_sccb_target;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       m_oe = 1'b0;
    wire        sda;
    logic       wr_strobe;
    logic [7:0] wr_reg, wr_data, rd_reg, rd_data;
    logic       busy;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_e;

    assign sda = m_oe ? 1'b0 : 1'bz;
    pullup (sda);

    assign rd_data = rd_reg ^ 8'hAF;

    always #5 clk = ~clk;

    sccb_target #(.DEVICE_ID(7'h21)) dut (
        .clk(clk), .reset(reset), .scl(scl), .sda(sda),
        .wr_strobe(wr_strobe), .wr_reg(wr_reg), .wr_data(wr_data),
        .rd_reg(rd_reg), .rd_data(rd_data), .busy(busy)
    );

    // Strobe monitor: every pulse must match the next expected write.
    always @(negedge clk) begin
        if (reset && wr_strobe) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe reg=%h data=%h, none expected",
                         wr_reg, wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                if ({wr_reg, wr_data} !== mon_e) begin
                    errors++;
                    $display("FAIL strobe got reg=%h data=%h want reg=%h data=%h",
                             wr_reg, wr_data, mon_e[15:8], mon_e[7:0]);
                end
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_xfer(input logic b, output logic r);
        wait_clk(2); m_oe = ~b;
        wait_clk(4); scl = 1'b1;
        wait_clk(3); r = sda;
        wait_clk(3); scl = 1'b0;
    endtask

    task automatic start_cond();
        m_oe = 1'b0;
        wait_clk(6); scl = 1'b1;
        wait_clk(6); m_oe = 1'b1;
        wait_clk(6); scl = 1'b0;
    endtask

    task automatic stop_cond();
        m_oe = 1'b1;
        wait_clk(6); scl = 1'b1;
        wait_clk(6); m_oe = 1'b0;
        wait_clk(6);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
        bit_xfer(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d,
                             output logic ackbit);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, r);
            d[i] = r;
        end
        bit_xfer(nack, ackbit);
    endtask

    task automatic test_reset();
        logic r;
        reset = 1'b0;
        #1;
        checks++;
        if ({sda, wr_strobe, busy, wr_reg, wr_data, rd_reg} !== {1'b1, 26'd0}) begin
            errors++;
            $display("FAIL reset_outputs sda=%b stb=%b busy=%b wr=%h/%h rd=%h want z,0,0,00/00/00",
                     sda, wr_strobe, busy, wr_reg, wr_data, rd_reg);
        end
        wait_clk(4);
        reset = 1'b1;
        wait_clk(4);
        scl = 1'b0;
        send_byte(8'h42, r);
        checks++;
        if (r !== 1'b1) begin
            errors++;
            $display("FAIL no_start_ack got %b want 1", r);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL no_start_busy got %b want 0", busy);
        end
    endtask

    task automatic test_write();
        logic a0, a1, a2;
        start_cond();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL write_busy_start got %b want 1", busy);
        end
        send_byte(8'h42, a0);
        send_byte(8'h12, a1);
        exp_q.push_back({8'h12, 8'h04});
        send_byte(8'h04, a2);
        stop_cond();
        checks++;
        if ({a0, a1, a2} !== 3'b000) begin
            errors++;
            $display("FAIL write_acks got %b want 000", {a0, a1, a2});
        end
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL write_end busy=%b pending=%0d want 0,0", busy, exp_q.size());
        end
    endtask

    task automatic test_burst();
        logic [3:0] a;
        start_cond();
        send_byte(8'h42, a[3]);
        send_byte(8'h40, a[2]);
        exp_q.push_back({8'h40, 8'hD0});
        send_byte(8'hD0, a[1]);
        exp_q.push_back({8'h41, 8'h11});
        send_byte(8'h11, a[0]);
        stop_cond();
        checks++;
        if (a !== 4'b0000 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL burst acks=%b pending=%0d want 0000,0", a, exp_q.size());
        end
    endtask

    task automatic test_read();
        logic a0, a1, a2, nk;
        logic [7:0] d;
        start_cond();
        send_byte(8'h42, a0);
        send_byte(8'h0A, a1);
        start_cond();
        send_byte(8'h43, a2);
        read_byte(1'b1, d, nk);
        stop_cond();
        checks++;
        if ({a0, a1, a2} !== 3'b000) begin
            errors++;
            $display("FAIL read_acks got %b want 000", {a0, a1, a2});
        end
        checks++;
        if (d !== 8'hA5) begin
            errors++;
            $display("FAIL read_data got %h want a5", d);
        end
        checks++;
        if (nk !== 1'b1) begin
            errors++;
            $display("FAIL read_ack_slot sda=%b want released 1", nk);
        end
        checks++;
        if (rd_reg !== 8'h0A || busy !== 1'b0) begin
            errors++;
            $display("FAIL read_end rd_reg=%h busy=%b want 0a,0", rd_reg, busy);
        end
    endtask

    task automatic test_read_burst();
        logic a0, a1, a2, k0, k1;
        logic [7:0] d0, d1;
        start_cond();
        send_byte(8'h42, a0);
        send_byte(8'h0A, a1);
        start_cond();
        send_byte(8'h43, a2);
        read_byte(1'b0, d0, k0);
        read_byte(1'b1, d1, k1);
        stop_cond();
        checks++;
        if ({d0, d1} !== 16'hA5A4) begin
            errors++;
            $display("FAIL read_burst data got %h %h want a5 a4", d0, d1);
        end
        checks++;
        if (rd_reg !== 8'h0B || {a0, a1, a2, k0, k1} !== 5'b00001) begin
            errors++;
            $display("FAIL read_burst rd_reg=%h bits=%b want 0b,00001",
                     rd_reg, {a0, a1, a2, k0, k1});
        end
    endtask

    task automatic test_ignore();
        logic a0, a1, a2;
        start_cond();
        send_byte(8'h60, a0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_busy got %b want 0", busy);
        end
        send_byte(8'h12, a1);
        send_byte(8'h34, a2);
        stop_cond();
        checks++;
        if ({a0, a1, a2} !== 3'b111) begin
            errors++;
            $display("FAIL ignore_acks got %b want 111", {a0, a1, a2});
        end
    endtask

    task automatic test_reset_mid_ack();
        logic r;
        logic [7:0] b;
        b = 8'h42;
        start_cond();
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
        wait_clk(2); m_oe = 1'b0;
        wait_clk(6);
        checks++;
        if (sda !== 1'b0) begin
            errors++;
            $display("FAIL mid_ack_drive sda=%b want 0", sda);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({sda, wr_strobe, busy, wr_reg, wr_data, rd_reg} !== {1'b1, 26'd0}) begin
            errors++;
            $display("FAIL mid_ack_reset sda=%b stb=%b busy=%b wr=%h/%h rd=%h want z,0,0,00/00/00",
                     sda, wr_strobe, busy, wr_reg, wr_data, rd_reg);
        end
        wait_clk(4);
        reset = 1'b1;
        wait_clk(4);
    endtask

    task automatic test_abort();
        logic a0, a1, r;
        start_cond();
        send_byte(8'h42, a0);
        send_byte(8'h12, a1);
        for (int i = 0; i < 4; i++) bit_xfer(1'b0, r);
        stop_cond();
        wait_clk(4);
        checks++;
        if ({a0, a1} !== 2'b00 || busy !== 1'b0 || sda !== 1'b1) begin
            errors++;
            $display("FAIL abort acks=%b busy=%b sda=%b want 00,0,1",
                     {a0, a1}, busy, sda);
        end
        checks++;
        if (exp_q.size() != 0 || wr_reg !== 8'h12) begin
            errors++;
            $display("FAIL abort pending=%0d wr_reg=%h want 0,12", exp_q.size(), wr_reg);
        end
    endtask

    initial begin
        #3;
        test_reset();
        test_write();
        test_burst();
        test_read();
        test_read_burst();
        test_ignore();
        test_reset_mid_ack();
        test_write();
        test_abort();
        wait_clk(10);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_strobes pending=%0d want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
